// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for DIV/DIVU: result and one-cycle done at WIDTH+1 cycles after start.
// Holds the pipeline via stall while in flight; flush cancels at any point and leaves lo/hi untouched.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             divz_q, divz_d;

  // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign trial  = {rem_q, quo_q[WIDTH-1]};
  assign diff   = trial - {1'b0, dvsr_q};
  assign borrow = diff[WIDTH];
  assign rem_nx = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~borrow};

  assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    a_d       = a_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d     = '0;
          quo_d     = a_abs;
          dvsr_d    = b_abs;
          a_d       = a;
          neg_quo_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_div & a[WIDTH-1];
          divz_d    = (b == '0);
          cnt_d     = '0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Outputs load on the final step so they are valid during DONE.
          lo_d    = divz_q ? '1  : (neg_quo_q ? -quo_nx : quo_nx);
          hi_d    = divz_q ? a_q : (neg_rem_q ? -rem_nx : rem_nx);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lo_d    = lo_q;
      hi_d    = hi_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      a_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      a_q       <= a_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
    end
  end

  // stall drops in DONE so the pipeline advances while HI/LO are written.
  assign stall = start & (state_q != S_DONE) & ~flush;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign lo    = lo_q;
  assign hi    = hi_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: vector table plus random ops through a result scoreboard,
// then flush, flush-vs-start priority and mid-operation reset sequences.
module tb_div_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         start;
  logic         signed_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;

  div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .lo        (lo),
    .hi        (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } res_t;

  res_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] last_lo;
  logic [W-1:0] last_hi;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding at %0t", $time);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("lo_result", lo, e.lo);
        chk("hi_result", hi, e.hi);
      end
    end
  end

  // Issues one divide at cycle 0 and walks it through to DONE at cycle W+1.
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi);
    res_t e;
    logic stall_bad;
    logic done_early;
    e.lo = elo;
    e.hi = ehi;
    sb.push_back(e);
    start      = 1'b1;
    signed_div = s;
    a          = av;
    b          = bv;
    stall_bad  = 1'b0;
    done_early = 1'b0;
    for (int c = 0; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 0) chk("busy_at_accept", busy, 0);
      if (c == 1) chk("busy_after_accept", busy, 1);
      if (c <= W) begin
        if (stall !== 1'b1) stall_bad = 1'b1;
        if (done !== 1'b0) done_early = 1'b1;
      end else begin
        chk("stall_in_done", stall, 0);
        chk("done_latency", done, 1);
      end
      @(posedge clk);
      #1;
      if (c == 2) begin
        a          = $urandom;
        b          = $urandom;
        signed_div = ~s;
      end
    end
    chk("stall_held_0_to_W", stall_bad, 0);
    chk("no_early_done", done_early, 0);
    start   = 1'b0;
    last_lo = elo;
    last_hi = ehi;
  endtask

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    logic [W-1:0]        ra;
    logic [W-1:0]        rb;
    logic                rs;
    int                  dcount;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'd1};
    tbl[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0};
    tbl[4]  = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678};
    tbl[5]  = '{1'b1, 32'h87654321,   32'd0,        32'hFFFFFFFF, 32'h87654321};
    tbl[6]  = '{1'b0, 32'd9,          32'd3,        32'd3,        32'd0};
    tbl[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    tbl[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    tbl[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0};
    tbl[10] = '{1'b0, 32'd5,          32'd10,       32'd0,        32'd5};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0};
    tbl[12] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};

    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    flush      = 1'b0;
    last_lo    = '0;
    last_hi    = '0;
    #2;
    chk("reset_lo", lo, 0);
    chk("reset_hi", hi, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors run back-to-back with start held across the boundary.
    for (int i = 0; i < 13; i++)
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? W'($urandom_range(1, 1000)) : W'($urandom);
      if (rb == '0) rb = 32'd3;
      rs = (i >= 8);
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
      if (rs) begin
        sa  = ra;
        sbv = rb;
        run_op(1'b1, ra, rb, W'(sa / sbv), W'(sa % sbv));
      end else begin
        run_op(1'b0, ra, rb, ra / rb, ra % rb);
      end
    end

    run_op(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);

    // Flush in cycle 10 of a 100/7 divide.
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("stall_low_on_flush", stall, 0);
    chk("busy_before_flush_edge", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_flush", busy, 0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("no_done_after_flush", W'(dcount), 0);
    chk("lo_kept_after_flush", lo, last_lo);
    chk("hi_kept_after_flush", hi, last_hi);

    // Flush beats start in IDLE.
    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    @(negedge clk);
    chk("stall_flush_vs_start", stall, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_flush_vs_start", busy, 0);
    @(posedge clk);
    #1;

    // Reset asserted in cycle 15 of an operation.
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    chk("busy_before_reset", busy, 1);
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    chk("midreset_lo", lo, 0);
    chk("midreset_hi", hi, 0);
    chk("midreset_done", done, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_stall", stall, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", W'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Iterative 32-cycle radix-2 restoring divider and its sequencing FSM for DIV/DIVU in the EX stage.
- Raises a stall request to the hazard unit while a divide is in flight.
- Presents quotient/remainder for the HI/LO write path with a one-cycle done pulse.
- Supports flush (exception/annul) cancellation.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH; counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction is DIV/DIVU; held high by the stalled pipeline until done.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start in IDLE.
- a  in  WIDTH  dividend (rs); sampled in IDLE when start=1.
- b  in  WIDTH  divisor (rt); sampled in IDLE when start=1.
- flush  in  1  cancel the current operation.
- stall  out  1  to hazard unit: hold F/D/E, bubble M.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse; lo/hi valid; HI/LO write enable.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, lo=0, hi=0, done=0, busy=0; stall=0 (combinational, start gated by state).
- Reset mid-operation aborts immediately; no done is produced.
- States and transitions:
  - IDLE: start=1 and flush=0 → capture |a|, |b|, sign_q = signed_div&(a[W-1]^b[W-1]), sign_r = signed_div&a[W-1]; clear partial remainder; counter=0 → BUSY.
  - BUSY: each cycle shift {rem,quo} left 1, trial-subtract divisor; if no borrow keep difference and set quo LSB=1; counter++. After WIDTH iterations → DONE.
  - DONE: lo/hi registered with sign fix applied; done=1 for exactly this cycle → IDLE.
- Latency: start accepted at cycle 0 → done high at cycle WIDTH+1 (33 for WIDTH=32). Next start is accepted no earlier than the cycle after DONE.
- stall = start & (state != DONE) & ~flush. Stall is high in the IDLE acceptance cycle and throughout BUSY, and low in DONE so the pipeline advances while HI/LO are written.
- Operands are captured once; changes on a/b/signed_div during BUSY are ignored.
- Sign fix: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem. Results use two's-complement wrap at WIDTH bits.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero (b=0), both signed and unsigned: lo=all ones, hi=a (original, unnegated). Full normal latency applies; no trap.
- flush:
  - Any state: next state=IDLE, counter cleared, no done.
  - lo/hi retain their previous values.
  - Flush has priority over start in the same cycle.
  - Flush during DONE: done is still asserted that cycle; the owner of HI/LO write-enable gates it with its own flush.
- lo/hi hold stable from done until the next DONE; they are not modified in BUSY (internal shift registers are separate from the output registers).
- busy = (state != IDLE).

Test Plan:
- Unsigned 100/7:
  - Expected response: stall high cycles 0–32, done only at cycle 33, lo=14, hi=2, stall low at 33.
- Signed 0xFFFFFFF9 (−7) / 2:
  - Expected response: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Same −7/2 with signed_div=0:
  - Expected response: lo=0x7FFFFFFC, hi=1.
- Signed 0x80000000 / 0xFFFFFFFF:
  - Expected response: lo=0x80000000, hi=0.
- Divide by zero, 0x12345678 / 0:
  - Expected response: lo=0xFFFFFFFF, hi=0x12345678, done at cycle 33.
- Flush at cycle 10 of 100/7:
  - Expected response: state IDLE at cycle 11, no done pulse, lo/hi keep prior values, stall low once flush is asserted.
- Back-to-back 100/7 then 9/3 (start held):
  - Expected response: second start accepted at cycle 34, done at cycle 67 with lo=3, hi=0.
- Reset mid-operation:
  - Stimulus: resetn asserted at cycle 15, then released, then a new start issued.
  - Expected response: all outputs zero immediately after the reset assertion; normal 33-cycle result after the new start.
